// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encodings, opcodes and instruction field helpers
package cpu_pkg;
  typedef enum logic [1:0] {ST_F = 2'd0, ST_D = 2'd1, ST_E = 2'd2, ST_W = 2'd3} state_t;
  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_INC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;
  localparam logic MODE_ALU = 1'b0;
  localparam logic MODE_LDI = 1'b1;
  localparam int MAX_IW = 32;
  function automatic logic instr_mode(input logic [MAX_IW-1:0] i, input int aw);
    return i[2*aw+3];
  endfunction
  function automatic logic [2:0] instr_op(input logic [MAX_IW-1:0] i, input int aw);
    return i[2*aw +: 3];
  endfunction
  function automatic logic [MAX_IW-1:0] instr_rd(input logic [MAX_IW-1:0] i, input int aw);
    return (i >> aw) & ((32'd1 << aw) - 32'd1);
  endfunction
  function automatic logic [MAX_IW-1:0] instr_rs(input logic [MAX_IW-1:0] i, input int aw);
    return i & ((32'd1 << aw) - 32'd1);
  endfunction
endpackage

// File: rtl/core_alu.sv
// core_alu: combinational 8-op ALU with carry/borrow and zero outputs
module core_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              carry,
  output logic              zero
);
  logic [DATA_W:0] sum, diff;
  // one shared adder serves ADD and INC; the extra top bit is carry-out or borrow
  always_comb begin
    sum = {1'b0, a} + {1'b0, (op == OP_INC) ? DATA_W'(1) : b};
    diff = {1'b0, a} - {1'b0, b};
    result = op == OP_MOV ? b :
             (op == OP_ADD || op == OP_INC) ? sum[DATA_W-1:0] :
             op == OP_SUB ? diff[DATA_W-1:0] :
             op == OP_AND ? a & b :
             op == OP_OR  ? a | b :
             op == OP_XOR ? a ^ b : ~b;
    carry = (op == OP_ADD || op == OP_INC) ? sum[DATA_W] : op == OP_SUB ? diff[DATA_W] : 1'b0;
    zero = ~|result;
  end
endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: fetch/decode/execute/writeback register-machine core
module multicycle_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS = 4,
  localparam int REG_AW = $clog2(NREGS),
  localparam int INSTR_W = 4 + 2 * REG_AW
) (
  input  logic               clock_pulse,
  input  logic               resetn,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic               wb_valid,
  output logic [REG_AW-1:0]  wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               flag_z,
  output logic               flag_c,
  output logic [1:0]         state,
  input  logic [REG_AW-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);
  state_t st, st_n;
  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0] a, b, res, alu_res;
  logic res_c, res_z, alu_c, alu_z;
  logic [DATA_W-1:0] regs [NREGS];
  logic [MAX_IW-1:0] ir_x;
  logic mode, arith, logic_op;
  logic [2:0] op;
  logic [REG_AW-1:0] rd, rs;
  assign ir_x = MAX_IW'(ir);
  assign mode = instr_mode(ir_x, REG_AW);
  assign op = instr_op(ir_x, REG_AW);
  assign rd = REG_AW'(instr_rd(ir_x, REG_AW));
  assign rs = REG_AW'(instr_rs(ir_x, REG_AW));
  assign arith = mode == MODE_ALU && (op == OP_ADD || op == OP_SUB || op == OP_INC);
  assign logic_op = mode == MODE_ALU && op[2];
  assign state = st;
  assign instr_ready = st == ST_F;
  assign dbg_data = regs[dbg_sel];
  core_alu #(.DATA_W(DATA_W)) u_alu (
    .op(op),
    .a(a),
    .b(b),
    .result(alu_res),
    .carry(alu_c),
    .zero(alu_z)
  );
  // state register; reset abandons any in-flight instruction
  always_ff @(posedge clock_pulse or negedge resetn) begin
    if (!resetn) st <= ST_F;
    else st <= st_n;
  end
  // F waits for a handshake, every other state advances unconditionally (W wraps to F)
  always_comb begin
    st_n = st == ST_F ? (instr_valid ? ST_D : ST_F) : state_t'(st + 2'd1);
  end
  // datapath: IR capture, operand latch, result register, register/flag writeback
  always_ff @(posedge clock_pulse or negedge resetn) begin
    if (!resetn) begin
      ir <= '0;
      a <= '0;
      b <= '0;
      res <= '0;
      res_c <= 1'b0;
      res_z <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      wb_valid <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (st == ST_F && instr_valid) ir <= instr;
      if (st == ST_D) begin
        a <= regs[rd];
        b <= regs[rs];
      end
      if (st == ST_E) begin
        res <= mode == MODE_LDI ? DATA_W'({op, rs}) : alu_res;
        res_c <= alu_c;
        res_z <= alu_z;
      end
      if (st == ST_W) begin
        regs[rd] <= res;
        wb_valid <= 1'b1;
        wb_addr <= rd;
        wb_data <= res;
        if (arith || logic_op) flag_z <= res_z;
        if (arith) flag_c <= res_c;
        else if (logic_op) flag_c <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed-vector self-checking bench for multicycle_core
module tb_multicycle_core;
  logic clock_pulse = 1'b0;
  logic resetn = 1'b0;
  logic [7:0] instr = 8'h00;
  logic instr_valid = 1'b0;
  logic [1:0] dbg_sel = 2'd0;
  logic instr_ready, wb_valid, flag_z, flag_c;
  logic [1:0] wb_addr, state;
  logic [31:0] wb_data, dbg_data;
  int errs = 0;
  int checks = 0;
  always #5 clock_pulse = ~clock_pulse;
  multicycle_core #(.DATA_W(32), .NREGS(4)) dut (
    .clock_pulse(clock_pulse),
    .resetn(resetn),
    .instr(instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .wb_valid(wb_valid),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .flag_z(flag_z),
    .flag_c(flag_c),
    .state(state),
    .dbg_sel(dbg_sel),
    .dbg_data(dbg_data)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [7:0] i, input bit noise, input logic [31:0] old,
                     input logic [31:0] val, input logic z, input logic c);
    int n;
    @(negedge clock_pulse);
    chk("ready", instr_ready, 1);
    dbg_sel = i[3:2];
    instr = i;
    instr_valid = 1'b1;
    @(posedge clock_pulse);
    #1;
    instr_valid = noise;
    instr = 8'hFF;
    chk("state_d", state, 1);
    n = 0;
    while (!wb_valid && n < 8) begin
      @(posedge clock_pulse);
      #1;
      n++;
      if (state == 2'd3) chk("old_in_w", dbg_data, old);
    end
    instr_valid = 1'b0;
    chk("latency", n, 3);
    chk("state_f", state, 0);
    chk("wb_addr", wb_addr, i[3:2]);
    chk("wb_data", wb_data, val);
    chk("dbg_new", dbg_data, val);
    chk("flag_z", flag_z, z);
    chk("flag_c", flag_c, c);
  endtask
  initial begin
    repeat (3) @(posedge clock_pulse);
    #1;
    chk("rst_state", state, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_z", flag_z, 0);
    chk("rst_c", flag_c, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wba", wb_addr, 0);
    chk("rst_wbd", wb_data, 0);
    for (int j = 0; j < 4; j++) begin
      dbg_sel = 2'(j);
      #1;
      chk("rst_reg", dbg_data, 0);
    end
    @(negedge clock_pulse);
    resetn = 1'b1;
    repeat (10) begin
      @(posedge clock_pulse);
      #1;
      chk("stall_state", state, 0);
      chk("stall_wbv", wb_valid, 0);
    end
    run(8'h95, 1'b1, 32'h0, 32'h5, 1'b0, 1'b0);
    @(posedge clock_pulse);
    #1;
    chk("noise_state", state, 0);
    chk("noise_wbv", wb_valid, 0);
    dbg_sel = 2'd3;
    #1;
    chk("noise_r3", dbg_data, 0);
    run(8'h21, 1'b0, 32'h0, 32'hFFFFFFFB, 1'b0, 1'b1);
    run(8'h30, 1'b0, 32'hFFFFFFFB, 32'hFFFFFFFC, 1'b0, 1'b0);
    run(8'h30, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFD, 1'b0, 1'b0);
    run(8'h30, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFE, 1'b0, 1'b0);
    run(8'h30, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0, 1'b0);
    run(8'h30, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
    run(8'hFB, 1'b0, 32'h0, 32'h1F, 1'b1, 1'b1);
    run(8'h6A, 1'b0, 32'h1F, 32'h0, 1'b1, 1'b0);
    @(negedge clock_pulse);
    instr = 8'h15;
    instr_valid = 1'b1;
    @(posedge clock_pulse);
    #1;
    instr_valid = 1'b0;
    @(posedge clock_pulse);
    #1;
    chk("mid_state_e", state, 2);
    resetn = 1'b0;
    dbg_sel = 2'd1;
    #1;
    chk("mid_state", state, 0);
    chk("mid_wbv", wb_valid, 0);
    chk("mid_r1", dbg_data, 0);
    chk("mid_z", flag_z, 0);
    @(posedge clock_pulse);
    #1;
    chk("mid_wbv2", wb_valid, 0);
    @(negedge clock_pulse);
    resetn = 1'b1;
    run(8'h95, 1'b0, 32'h0, 32'h5, 1'b0, 1'b0);
    run(8'hB8, 1'b0, 32'h0, 32'hC, 1'b0, 1'b0);
    run(8'h46, 1'b0, 32'h5, 32'h4, 1'b0, 1'b0);
    run(8'h56, 1'b0, 32'h4, 32'hC, 1'b0, 1'b0);
    run(8'h7D, 1'b0, 32'h0, 32'hFFFFFFF3, 1'b0, 1'b0);
    run(8'h03, 1'b0, 32'h0, 32'hFFFFFFF3, 1'b0, 1'b0);
    run(8'h10, 1'b0, 32'hFFFFFFF3, 32'hFFFFFFE6, 1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
